// File: rtl/vid_pkg.sv
// Shared video constants, size helpers and the packed pixel layout.
package vid_pkg;

    localparam int DEF_H_ACTIVE   = 800;
    localparam int DEF_V_ACTIVE   = 600;
    localparam int DEF_COLOR_BITS = 2;

    // One stored pixel as it sits in the framebuffer word: red in the MSBs.
    typedef struct packed {
        logic [DEF_COLOR_BITS-1:0] red;
        logic [DEF_COLOR_BITS-1:0] green;
        logic [DEF_COLOR_BITS-1:0] blue;
    } pixel_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Stored words per line after pixel replication.
    function automatic int line_words(input int h_active, input int scale_shift);
        return h_active >> scale_shift;
    endfunction

    // Stored words per frame after pixel replication.
    function automatic int frame_words(input int h_active, input int v_active,
                                       input int scale_shift);
        return (h_active >> scale_shift) * (v_active >> scale_shift);
    endfunction

endpackage

// File: rtl/scan_addr_gen.sv
// Incremental framebuffer address generator (stage 0) and tear-free frame latch.
module scan_addr_gen
    import vid_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_CNT_W     = 11,
    parameter int V_CNT_W     = 10,
    parameter int SCALE_SHIFT = 1,
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_W     = 1,
    parameter int ADDR_W      = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [H_CNT_W-1:0] h_count,
    input  logic [V_CNT_W-1:0] v_count,
    input  logic [FRAME_W-1:0] frame_sel,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_en,
    output logic [FRAME_W-1:0] cur_frame,
    output logic               frame_err
);

    localparam int LINE_W      = line_words(H_ACTIVE, SCALE_SHIFT);
    localparam int FRAME_WORDS = frame_words(H_ACTIVE, V_ACTIVE, SCALE_SHIFT);
    localparam longint TOTAL_WORDS = longint'(NUM_FRAMES) * longint'(FRAME_WORDS);

    localparam logic [H_CNT_W-1:0] H_LIM    = H_CNT_W'(H_ACTIVE);
    localparam logic [V_CNT_W-1:0] V_LIM    = V_CNT_W'(V_ACTIVE);
    localparam logic [V_CNT_W-1:0] ROW_MASK = V_CNT_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0]  LINE_STEP = ADDR_W'(LINE_W);

    // All frames must fit the address space so the address can never wrap.
    if (TOTAL_WORDS > (longint'(1) << ADDR_W)) begin : g_addr_too_narrow
        $error("scan_addr_gen: NUM_FRAMES*FRAME_WORDS exceeds 2**ADDR_W");
    end

    // Base of frame 'sel' as a mux of constants rather than a multiplier.
    function automatic logic [ADDR_W-1:0] frame_base(input logic [FRAME_W-1:0] sel);
        logic [ADDR_W-1:0] b;
        b = '0;
        for (int i = 0; i < NUM_FRAMES; i++) begin
            if (int'(sel) == i) b = ADDR_W'(longint'(i) * longint'(FRAME_WORDS));
        end
        return b;
    endfunction

    logic [ADDR_W-1:0]  line_base_q, line_base_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic               ram_en_q, ram_en_d;
    logic [FRAME_W-1:0] cur_frame_q, cur_frame_d;
    logic               frame_err_q, frame_err_d;
    logic [ADDR_W-1:0]  base_now;
    logic               act;

    assign act = (h_count < H_LIM) && (v_count < V_LIM);

    // Line base advances once per stored line; the column is the replicated h index.
    always_comb begin
        line_base_d = line_base_q;
        ram_addr_d  = ram_addr_q;
        ram_en_d    = act;
        cur_frame_d = cur_frame_q;
        frame_err_d = 1'b0;
        base_now    = line_base_q;

        if (h_count == '0 && v_count == '0) begin
            base_now = frame_base(cur_frame_q);
        end else if (act && h_count == '0 && (v_count & ROW_MASK) == '0) begin
            base_now = line_base_q + LINE_STEP;
        end

        if (act) begin
            line_base_d = base_now;
            ram_addr_d  = base_now + ADDR_W'(h_count >> SCALE_SHIFT);
        end

        // Frame selection only moves on the first blanking line, never mid-picture.
        if (h_count == '0 && v_count == V_LIM) begin
            if (int'(frame_sel) < NUM_FRAMES) begin
                cur_frame_d = frame_sel;
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    // Stage 0 registers and frame latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_base_q <= '0;
            ram_addr_q  <= '0;
            ram_en_q    <= 1'b0;
            cur_frame_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            line_base_q <= line_base_d;
            ram_addr_q  <= ram_addr_d;
            ram_en_q    <= ram_en_d;
            cur_frame_q <= cur_frame_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign ram_addr  = ram_addr_q;
    assign ram_en    = ram_en_q;
    assign cur_frame = cur_frame_q;
    assign frame_err = frame_err_q;

endmodule

// File: rtl/frame_scan_reader.sv
// Framebuffer scan-out: address generation, RAM-latency alignment, registered colour.
module frame_scan_reader
    import vid_pkg::*;
#(
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int H_CNT_W     = 11,
    parameter int V_CNT_W     = 10,
    parameter int SCALE_SHIFT = 1,
    parameter int COLOR_BITS  = DEF_COLOR_BITS,
    parameter int NUM_FRAMES  = 2,
    parameter int FRAME_W     = (clog2(NUM_FRAMES) < 1) ? 1 : clog2(NUM_FRAMES),
    parameter int ADDR_W      = 18,
    parameter int RAM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [H_CNT_W-1:0]      h_count,
    input  logic [V_CNT_W-1:0]      v_count,
    input  logic [FRAME_W-1:0]      frame_sel,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic                    ram_en,
    input  logic [3*COLOR_BITS-1:0] ram_rdata,
    output logic [COLOR_BITS-1:0]   red,
    output logic [COLOR_BITS-1:0]   green,
    output logic [COLOR_BITS-1:0]   blue,
    output logic                    pix_valid,
    output logic [FRAME_W-1:0]      cur_frame,
    output logic                    frame_err
);

    if (RAM_LATENCY < 1 || RAM_LATENCY > 3) begin : g_bad_latency
        $error("frame_scan_reader: RAM_LATENCY must be 1..3");
    end

    typedef struct packed {
        logic [COLOR_BITS-1:0] red;
        logic [COLOR_BITS-1:0] green;
        logic [COLOR_BITS-1:0] blue;
    } pix_t;

    scan_addr_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .H_CNT_W    (H_CNT_W),
        .V_CNT_W    (V_CNT_W),
        .SCALE_SHIFT(SCALE_SHIFT),
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_W    (FRAME_W),
        .ADDR_W     (ADDR_W)
    ) u_addr (
        .clk      (clk),
        .rst      (rst),
        .h_count  (h_count),
        .v_count  (v_count),
        .frame_sel(frame_sel),
        .ram_addr (ram_addr),
        .ram_en   (ram_en),
        .cur_frame(cur_frame),
        .frame_err(frame_err)
    );

    logic [RAM_LATENCY-1:0] act_dly_q, act_dly_d;
    pix_t                   pix_q, pix_d;
    logic                   pix_valid_q, pix_valid_d;

    // Delay the stage-0 active flag by the RAM read latency; blank outside it.
    always_comb begin
        act_dly_d   = (act_dly_q << 1) | RAM_LATENCY'(ram_en);
        pix_d       = '0;
        pix_valid_d = 1'b0;
        if (act_dly_q[RAM_LATENCY-1]) begin
            pix_d       = pix_t'(ram_rdata);
            pix_valid_d = 1'b1;
        end
    end

    // Alignment shift register and registered colour outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_dly_q   <= '0;
            pix_q       <= '0;
            pix_valid_q <= 1'b0;
        end else begin
            act_dly_q   <= act_dly_d;
            pix_q       <= pix_d;
            pix_valid_q <= pix_valid_d;
        end
    end

    assign red       = pix_q.red;
    assign green     = pix_q.green;
    assign blue      = pix_q.blue;
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_frame_scan_reader.sv
// Scoreboard bench: three parameterisations of frame_scan_reader share the counters.
module tb_frame_scan_reader;

    typedef struct {
        int         due;
        logic       vld;
        logic [5:0] rgb;
    } pix_exp_t;

    typedef struct {
        int          due;
        logic        en;
        logic [19:0] addr;
        logic [1:0]  cf;
        logic        err;
    } ctl_exp_t;

    typedef struct {
        int d;
        int f;
        int h;
        int v;
        int addr;
    } dir_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_count = '0;
    logic [9:0]  v_count = '0;
    logic [0:0]  fsel0 = '0;
    logic [1:0]  fsel1 = '0;
    logic [0:0]  fsel2 = '0;

    logic [17:0] ram_addr0;
    logic [18:0] ram_addr1;
    logic [19:0] ram_addr2;
    logic        ram_en0, ram_en1, ram_en2;
    logic [5:0]  rdata0, rdata1, rdata2;
    logic [1:0]  red0, green0, blue0, red1, green1, blue1, red2, green2, blue2;
    logic        pv0, pv1, pv2;
    logic [0:0]  cf0;
    logic [1:0]  cf1;
    logic [0:0]  cf2;
    logic        err0, err1, err2;

    int edge_cnt = 0;
    int n_chk = 0;
    int n_fail = 0;

    int NF_A[3]  = '{2, 3, 2};
    int SS_A[3]  = '{1, 1, 0};
    int LAT_A[3] = '{1, 1, 3};
    int FW_A[3]  = '{120000, 120000, 480000};
    int LW_A[3]  = '{400, 400, 800};
    int HL[13]   = '{0, 1, 2, 3, 4, 5, 796, 797, 798, 799, 800, 1000, 1055};
    int BV[5]    = '{600, 601, 602, 700, 1023};

    int          cf_m[3];
    logic [19:0] addr_m[3];
    dir_t        dir_tab[9];

    pix_exp_t pq0[$], pq1[$], pq2[$];
    ctl_exp_t cq0[$], cq1[$], cq2[$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [5:0] memf(input logic [31:0] a);
        logic [31:0] t;
        t = a ^ (a >> 6) ^ (a >> 12) ^ (a >> 18);
        return t[5:0];
    endfunction

    // Behavioural RAMs with the latency each instance is configured for.
    logic [5:0] rnd_q;
    logic [5:0] rd0_q, rd1_q;
    logic [5:0] rd2_q[3];
    always @(posedge clk) begin
        rnd_q    <= 6'($urandom);
        rd0_q    <= memf(32'(ram_addr0));
        rd1_q    <= memf(32'(ram_addr1));
        rd2_q[0] <= memf(32'(ram_addr2));
        rd2_q[1] <= rd2_q[0];
        rd2_q[2] <= rd2_q[1];
    end
    assign rdata0 = rst ? rnd_q : rd0_q;
    assign rdata1 = rst ? ~rnd_q : rd1_q;
    assign rdata2 = rst ? rnd_q : rd2_q[2];

    frame_scan_reader u_dut0 (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .frame_sel(fsel0),
        .ram_addr(ram_addr0), .ram_en(ram_en0), .ram_rdata(rdata0),
        .red(red0), .green(green0), .blue(blue0), .pix_valid(pv0),
        .cur_frame(cf0), .frame_err(err0)
    );

    frame_scan_reader #(.NUM_FRAMES(3), .FRAME_W(2), .ADDR_W(19)) u_dut1 (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .frame_sel(fsel1),
        .ram_addr(ram_addr1), .ram_en(ram_en1), .ram_rdata(rdata1),
        .red(red1), .green(green1), .blue(blue1), .pix_valid(pv1),
        .cur_frame(cf1), .frame_err(err1)
    );

    frame_scan_reader #(.SCALE_SHIFT(0), .ADDR_W(20), .RAM_LATENCY(3)) u_dut2 (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count), .frame_sel(fsel2),
        .ram_addr(ram_addr2), .ram_en(ram_en2), .ram_rdata(rdata2),
        .red(red2), .green(green2), .blue(blue2), .pix_valid(pv2),
        .cur_frame(cf2), .frame_err(err2)
    );

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at edge %0d: got %0d required %0d", nm, edge_cnt, got, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input ctl_exp_t c, input logic en,
                           input logic [19:0] addr, input logic [1:0] cf, input logic err);
        cmp({nm, " due"}, 32'(c.due), 32'(edge_cnt));
        cmp({nm, " ram_en"}, 32'(en), 32'(c.en));
        cmp({nm, " ram_addr"}, 32'(addr), 32'(c.addr));
        cmp({nm, " cur_frame"}, 32'(cf), 32'(c.cf));
        cmp({nm, " frame_err"}, 32'(err), 32'(c.err));
    endtask

    task automatic chk_pix(input string nm, input pix_exp_t p, input logic vld,
                           input logic [5:0] rgb);
        cmp({nm, " due"}, 32'(p.due), 32'(edge_cnt));
        cmp({nm, " pix_valid"}, 32'(vld), 32'(p.vld));
        cmp({nm, " rgb"}, 32'(rgb), 32'(p.rgb));
    endtask

    // Monitor: pop every expectation that falls due at this edge and compare.
    always @(negedge clk) begin
        ctl_exp_t c;
        pix_exp_t p;
        while (cq0.size() > 0 && cq0[0].due <= edge_cnt) begin
            c = cq0.pop_front();
            chk_ctl("d0", c, ram_en0, 20'(ram_addr0), 2'(cf0), err0);
        end
        while (cq1.size() > 0 && cq1[0].due <= edge_cnt) begin
            c = cq1.pop_front();
            chk_ctl("d1", c, ram_en1, 20'(ram_addr1), cf1, err1);
        end
        while (cq2.size() > 0 && cq2[0].due <= edge_cnt) begin
            c = cq2.pop_front();
            chk_ctl("d2", c, ram_en2, ram_addr2, 2'(cf2), err2);
        end
        while (pq0.size() > 0 && pq0[0].due <= edge_cnt) begin
            p = pq0.pop_front();
            chk_pix("d0", p, pv0, {red0, green0, blue0});
        end
        while (pq1.size() > 0 && pq1[0].due <= edge_cnt) begin
            p = pq1.pop_front();
            chk_pix("d1", p, pv1, {red1, green1, blue1});
        end
        while (pq2.size() > 0 && pq2[0].due <= edge_cnt) begin
            p = pq2.pop_front();
            chk_pix("d2", p, pv2, {red2, green2, blue2});
        end
    end

    // Present one counter value, queue what every instance must show, advance a clock.
    task automatic drive(input int h, input int v, input logic r);
        int       e;
        int       a;
        int       sel;
        logic     act;
        ctl_exp_t c;
        pix_exp_t p;
        h_count = 11'(h);
        v_count = 10'(v);
        rst     = r;
        e       = edge_cnt + 1;
        act     = (h < 800) && (v < 600);
        if (r) begin
            for (int i = 0; i < pq0.size(); i++) if (pq0[i].due >= e) begin pq0[i].vld = 1'b0; pq0[i].rgb = '0; end
            for (int i = 0; i < pq1.size(); i++) if (pq1[i].due >= e) begin pq1[i].vld = 1'b0; pq1[i].rgb = '0; end
            for (int i = 0; i < pq2.size(); i++) if (pq2[i].due >= e) begin pq2[i].vld = 1'b0; pq2[i].rgb = '0; end
        end
        for (int d = 0; d < 3; d++) begin
            sel = (d == 0) ? int'(fsel0) : (d == 1) ? int'(fsel1) : int'(fsel2);
            a = cf_m[d] * FW_A[d] + (v >> SS_A[d]) * LW_A[d] + (h >> SS_A[d]);
            for (int k = 0; k < 9; k++) begin
                if (dir_tab[k].d == d && dir_tab[k].f == cf_m[d] &&
                    dir_tab[k].h == h && dir_tab[k].v == v) a = dir_tab[k].addr;
            end
            c.err = 1'b0;
            if (r) begin
                addr_m[d] = '0;
                cf_m[d]   = 0;
                c.en      = 1'b0;
            end else begin
                c.en = act;
                if (act) addr_m[d] = 20'(a);
                if (h == 0 && v == 600) begin
                    if (sel < NF_A[d]) cf_m[d] = sel;
                    else c.err = 1'b1;
                end
            end
            c.due  = e;
            c.addr = addr_m[d];
            c.cf   = 2'(cf_m[d]);
            p.due  = e + LAT_A[d] + 1;
            p.vld  = act && !r;
            p.rgb  = p.vld ? memf(32'(a)) : 6'd0;
            case (d)
                0: begin cq0.push_back(c); pq0.push_back(p); end
                1: begin cq1.push_back(c); pq1.push_back(p); end
                default: begin cq2.push_back(c); pq2.push_back(p); end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input int nlines, input int rst_line);
        for (int v = 0; v < nlines; v++) begin
            if (v == 300) begin
                fsel0 = 1'b1;
                fsel1 = 2'd3;
                fsel2 = 1'b1;
            end
            for (int i = 0; i < 13; i++) drive(HL[i], v, (v == rst_line) && (i >= 4));
            if (v == rst_line) return;
        end
    endtask

    task automatic blank_lines();
        for (int i = 0; i < 5; i++) begin
            drive(0, BV[i], 1'b0);
            drive(1, BV[i], 1'b0);
            drive(800, BV[i], 1'b0);
            drive(2047, BV[i], 1'b0);
        end
    endtask

    initial begin
        dir_tab[0] = '{0, 0, 0, 0, 0};
        dir_tab[1] = '{0, 0, 2, 2, 401};
        dir_tab[2] = '{0, 0, 799, 599, 119999};
        dir_tab[3] = '{0, 1, 0, 0, 120000};
        dir_tab[4] = '{0, 1, 799, 599, 239999};
        dir_tab[5] = '{1, 0, 799, 599, 119999};
        dir_tab[6] = '{2, 0, 5, 3, 2405};
        dir_tab[7] = '{2, 1, 0, 0, 480000};
        dir_tab[8] = '{2, 1, 799, 599, 959999};
        for (int d = 0; d < 3; d++) begin
            cf_m[d]   = 0;
            addr_m[d] = '0;
        end

        @(posedge clk);
        #1;
        // Reset held while the counters sweep active video.
        for (int i = 0; i < 16; i++) drive(100 + i, 10, 1'b1);
        for (int i = 0; i < 4; i++) drive(800 + i, 610, 1'b0);
        // Frame A: selection requests change half way down.
        scan_frame(600, -1);
        blank_lines();
        // Frame B: reset lands mid-line near the bottom.
        scan_frame(600, 598);
        blank_lines();
        // Frame C: a few lines after resynchronising.
        scan_frame(4, -1);
        blank_lines();

        repeat (8) @(negedge clk);
        cmp("queues drained", 32'(cq0.size() + cq1.size() + cq2.size() +
                                  pq0.size() + pq1.size() + pq2.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/frame_scan_reader.md
Name: frame_scan_reader

Overview:
- Parametrised successor to the single-purpose pixel loader.
- Turns the VGA timing counters into framebuffer read addresses for a packed-RGB BRAM.
- Supports configurable colour depth, integer pixel-doubling (power of two), and N selectable frames with tear-free switching.
- Registers colour outputs pipeline-aligned to the counters, so the VGA top sees the colour for pixel (h,v) at a fixed, known latency.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- V_ACTIVE, 600, visible lines per frame
- H_CNT_W, 11, width of h_count
- V_CNT_W, 10, width of v_count
- SCALE_SHIFT, 1, log2 of pixel replication factor (1 means each stored pixel covers 2x2 screen pixels)
- COLOR_BITS, 2, bits per colour channel
- NUM_FRAMES, 2, frames stored back-to-back in RAM
- FRAME_W, 1, width of frame_sel, equal to clog2(NUM_FRAMES) with a minimum of 1
- ADDR_W, 18, RAM address width
- RAM_LATENCY, 1, read latency of the RAM in clk cycles, range 1..3

Ports:
- clk  in  1  pixel clock; the only clock in the block
- rst  in  1  synchronous, active-high reset
- h_count  in  H_CNT_W  horizontal counter from the timing generator
- v_count  in  V_CNT_W  vertical counter from the timing generator
- frame_sel  in  FRAME_W  requested frame index, may change at any time
- ram_addr  out  ADDR_W  RAM read address
- ram_en  out  1  RAM read enable
- ram_rdata  in  3*COLOR_BITS  packed read data, {red, green, blue}, red in the MSBs
- red  out  COLOR_BITS  registered red channel
- green  out  COLOR_BITS  registered green channel
- blue  out  COLOR_BITS  registered blue channel
- pix_valid  out  1  high when red/green/blue hold an active pixel
- cur_frame  out  FRAME_W  frame currently being displayed
- frame_err  out  1  one-cycle pulse: an out-of-range frame_sel was rejected

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: red, green, blue = 0; pix_valid = 0; ram_en = 0; ram_addr = 0; cur_frame = 0; frame_err = 0. All pipeline valid bits are cleared.
- Reset mid-frame: outputs read black from the next cycle. After reset deasserts, addressing resynchronises from the counters with no further action.
- Derived constants:
  - LINE_W = H_ACTIVE >> SCALE_SHIFT
  - FRAME_WORDS = LINE_W * (V_ACTIVE >> SCALE_SHIFT)
  - Default values give LINE_W = 400 and FRAME_WORDS = 120000.
- Active region: act = (h_count < H_ACTIVE) && (v_count < V_ACTIVE).
- Stage 0 (registered at the first clk edge after the counters are presented):
  - ram_en <= act.
  - When act, ram_addr <= cur_frame*FRAME_WORDS + (v_count>>SCALE_SHIFT)*LINE_W + (h_count>>SCALE_SHIFT).
  - When not act, ram_addr holds its value.
  - The address must be generated without a runtime multiplier:
    - a line-base register is loaded with cur_frame*FRAME_WORDS at (h=0, v=0);
    - it is incremented by LINE_W at h_count==0 on each active line where v_count[SCALE_SHIFT-1:0]==0 and v_count!=0;
    - a column term advances by 1 every 2^SCALE_SHIFT active pixels.
  - The result must equal the formula above for every active (h,v).
- Alignment: act is delayed through a shift register of depth RAM_LATENCY. At the output stage:
  - if the delayed act is 1, {red,green,blue} <= ram_rdata and pix_valid <= 1;
  - otherwise red, green, blue and pix_valid <= 0.
- Total latency from counter value to colour output is RAM_LATENCY+2 cycles (3 cycles with the default RAM_LATENCY=1). The timing top compensates its sync outputs by this amount.
- Frame switching:
  - frame_sel is sampled only at h_count==0 && v_count==V_ACTIVE, the first blanking line.
  - At that point cur_frame <= frame_sel if frame_sel < NUM_FRAMES.
  - Otherwise cur_frame is kept and frame_err pulses for 1 cycle.
  - cur_frame never changes during the active region, so there is no tearing.
- Boundaries:
  - The last pixel (H_ACTIVE-1, V_ACTIVE-1) maps to address frame_base + FRAME_WORDS - 1.
  - Address arithmetic is ADDR_W wide. NUM_FRAMES*FRAME_WORDS must be <= 2^ADDR_W; this is checked with an elaboration-time assertion and the address never wraps.
  - Counter values beyond the total line or frame length are treated as blanking.
  - SCALE_SHIFT=0 gives 1:1 mapping.

Decomposition:
- Shared package vid_pkg holds:
  - the default timing constants H_ACTIVE and V_ACTIVE;
  - a function computing LINE_W and FRAME_WORDS;
  - clog2;
  - the packed pixel type (pixel_t: red, green, blue fields of COLOR_BITS each).
- One natural sub-module, scan_addr_gen: incremental line-base/column address generator containing stage 0 and the frame latch.
- The top holds the latency shift register and the output stage.

Test Plan:
- Reset held during active video with random ram_rdata -> red, green, blue, pix_valid, ram_en all 0. First active pixel after release has ram_addr=0 with frame 0.
- Default parameters, frame_sel=0, full frame -> at (h=799, v=599) ram_addr=119999. At (h=2, v=2) ram_addr=401. Colour equals the RAM model's data exactly 3 cycles after the counter value.
- frame_sel toggled 0->1 at v=300 -> cur_frame stays 0 until h=0, v=600, then becomes 1. Next frame's (0,0) address is 120000.
- Parameters NUM_FRAMES=3, FRAME_W=2 with frame_sel=3 at the sample point -> frame_err high for exactly 1 cycle, cur_frame unchanged.
- RAM_LATENCY=3 with SCALE_SHIFT=0 -> every output pixel matches the model delayed by 5 cycles. During blanking (h>=800), pix_valid=0 and colours are 0.
